answer_entry: RTL and testbench
===============================

Name: answer_entry

Overview:
- Sequential decimal-to-binary entry block, the input-side counterpart of the digit display chain.
- Accepts one decimal digit strobe at a time from the keypad/button decoder and builds the player's answer (0-999) most-significant digit first.
- Supports backspace and clear, and exposes the live value for the three-digit display.
- On submit, hands the binary answer to the game checker over a valid/ready handshake.

Parameters:
- MAX_DIGITS, 3, maximum digits held (1..3).
- VALUE_W, 10, width of value/result; must hold 10^MAX_DIGITS-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- digit_valid  in  1  single-cycle strobe, digit present
- digit  in  4  decimal digit, legal 0..9
- backspace  in  1  single-cycle strobe, remove last digit
- clear  in  1  single-cycle strobe, discard entry
- submit  in  1  single-cycle strobe, commit entry
- result_ready  in  1  checker accepts result
- value  out  VALUE_W  live entered value, binary, to display
- num_digits  out  2  digits currently entered (0..MAX_DIGITS)
- result_valid  out  1  committed answer available
- result  out  VALUE_W  committed answer, stable while result_valid
- error  out  1  one-cycle pulse on any rejected operation

Behaviour:
- Reset, asynchronous on rst_n low:
  - value=0, num_digits=0, result_valid=0, result=0, error=0, digit stack=0, state=EMPTY.
  - Reset mid-handshake drops result_valid immediately; no result is delivered.
- States:
  - EMPTY: num_digits=0.
  - ENTRY: 1..MAX_DIGITS digits held.
  - HOLD: result_valid=1, awaiting result_ready.
- Event priority within a cycle (EMPTY/ENTRY): clear > backspace > submit > digit_valid. Only the highest-priority asserted event acts. Lower-priority events in the same cycle are dropped silently, with no error.
- All register updates, including value and num_digits, are visible the cycle after the strobe (1-cycle latency).
- digit_valid, digit<=9, num_digits<MAX_DIGITS:
  - value <= value*10 + digit; num_digits += 1; EMPTY->ENTRY.
  - Leading zeros count as digits: entering 0 then 7 gives num_digits=2, value=7.
- digit_valid with digit>9, or with num_digits==MAX_DIGITS: no state change, error=1 for one cycle.
- backspace:
  - In ENTRY: drop last digit; value <= value/10, computed from the stored digit stack (no divider); num_digits -= 1. Reaching 0 digits returns to EMPTY with value=0.
  - In EMPTY: error pulse, no change.
- clear: value=0, num_digits=0, ->EMPTY. No error, even if already empty.
- submit:
  - In ENTRY: result <= value, result_valid <= 1, ->HOLD. value and num_digits are unchanged during HOLD so the display keeps showing the answer.
  - In EMPTY: error pulse, no result.
- HOLD:
  - All strobes (digit_valid, backspace, clear, submit) are ignored, with no error pulse.
  - Transfer occurs on a rising edge with result_valid & result_ready. Next cycle: result_valid=0, value=0, num_digits=0, ->EMPTY.
  - result_ready high in the same cycle as submit has no effect; result_valid must be seen first.
  - result_ready may be held high permanently, giving a single-cycle result_valid pulse.
- error is a registered output, high exactly one cycle after the offending strobe.
- Width: multiply-accumulate is done at VALUE_W+4 bits internally, then truncated. The max-digit guard makes overflow impossible.

Test Plan:
- Reset, then strobe digits 4,0,7 on separate cycles -> value 4, 40, 407; num_digits 1, 2, 3; error stays 0.
- After 407, digit 5 -> error pulses 1 cycle, value stays 407. Then backspace twice -> value 40, then 4, num_digits 1. Then backspace, then backspace -> value 0, EMPTY, second backspace pulses error.
- Enter 9,9; submit with result_ready=0 for 5 cycles -> result_valid=1, result=99 held stable; digit 3 and clear during HOLD ignored. Raise result_ready -> result_valid drops next cycle, value=0, num_digits=0.
- Same cycle: clear+digit_valid(6) with value=12 -> value=0, num_digits=0, no error. Same cycle: backspace+submit with value=12 -> value=1, no result_valid.
- digit=12 with digit_valid -> error pulse, value unchanged. submit while EMPTY -> error pulse, result_valid stays 0.
- Enter 3, submit, assert rst_n low mid-HOLD, asynchronously between edges -> result_valid, value, num_digits go 0 immediately. After release, digit 8 -> value 8.

Source files
------------

// File: rtl/answer_entry.sv
// Keypad answer entry: builds a 0..10^MAX_DIGITS-1 value MSD-first from digit strobes,
// supports backspace/clear, and hands the committed answer over a valid/ready handshake.
module answer_entry #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned VALUE_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [3:0]         digit,
  input  logic               backspace,
  input  logic               clear,
  input  logic               submit,
  input  logic               result_ready,
  output logic [VALUE_W-1:0] value,
  output logic [1:0]         num_digits,
  output logic               result_valid,
  output logic [VALUE_W-1:0] result,
  output logic               error
);

  localparam int unsigned STACK_W = 4 * MAX_DIGITS;
  localparam int unsigned ACC_W   = VALUE_W + 4;
  localparam logic [1:0]  MAX_ND  = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    HOLD
  } state_e;

  state_e               state_q;
  logic [VALUE_W-1:0]   value_q;
  logic [VALUE_W-1:0]   result_q;
  logic [1:0]           nd_q;
  logic                 rv_q;
  logic                 err_q;
  logic [STACK_W-1:0]   stack_q;

  logic [ACC_W-1:0]     value_push;
  logic [ACC_W-1:0]     value_pop;
  logic                 digit_ok;

  // Newest digit lives in the low nibble; unused upper nibbles are always zero, so
  // re-accumulating every nibble except the newest yields value/10 without a divider.
  always_comb begin
    value_push = ({4'b0000, value_q} << 3) + ({4'b0000, value_q} << 1) + ACC_W'(digit);
    value_pop  = '0;
    for (int unsigned k = 1; k < MAX_DIGITS; k++) begin
      value_pop = (value_pop << 3) + (value_pop << 1)
                + ACC_W'(stack_q[4*(MAX_DIGITS-k) +: 4]);
    end
    digit_ok = (digit <= 4'd9) && (nd_q < MAX_ND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      value_q  <= '0;
      result_q <= '0;
      nd_q     <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      stack_q  <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        EMPTY, ENTRY: begin
          if (clear) begin
            value_q <= '0;
            nd_q    <= '0;
            stack_q <= '0;
            state_q <= EMPTY;
          end else if (backspace) begin
            if (state_q == EMPTY) begin
              err_q <= 1'b1;
            end else begin
              value_q <= value_pop[VALUE_W-1:0];
              nd_q    <= nd_q - 2'd1;
              stack_q <= stack_q >> 4;
              state_q <= (nd_q == 2'd1) ? EMPTY : ENTRY;
            end
          end else if (submit) begin
            if (state_q == EMPTY) begin
              err_q <= 1'b1;
            end else begin
              result_q <= value_q;
              rv_q     <= 1'b1;
              state_q  <= HOLD;
            end
          end else if (digit_valid) begin
            if (digit_ok) begin
              value_q <= value_push[VALUE_W-1:0];
              nd_q    <= nd_q + 2'd1;
              stack_q <= (stack_q << 4) | STACK_W'(digit);
              state_q <= ENTRY;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            rv_q    <= 1'b0;
            value_q <= '0;
            nd_q    <= '0;
            stack_q <= '0;
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign value        = value_q;
  assign num_digits   = nd_q;
  assign result_valid = rv_q;
  assign result       = result_q;
  assign error        = err_q;

endmodule

// File: tb/tb_answer_entry.sv
// Directed table-driven bench for answer_entry plus hand-written reset sequences.
module tb_answer_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       digit_valid, backspace, clear, submit, result_ready;
  logic [3:0] digit;
  logic [9:0] value, result;
  logic [1:0] num_digits;
  logic       result_valid, error;

  int errors = 0;
  int checks = 0;

  answer_entry #(.MAX_DIGITS(3), .VALUE_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .backspace(backspace), .clear(clear), .submit(submit),
    .result_ready(result_ready), .value(value), .num_digits(num_digits),
    .result_valid(result_valid), .result(result), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [3:0] dig;
    logic       bs;
    logic       clr;
    logic       sub;
    logic       rdy;
    int         e_value;
    int         e_nd;
    int         e_rv;
    int         e_result;
    int         e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic dv, input int dig, input logic bs, input logic clr,
                     input logic sub, input logic rdy, input int ev, input int end_,
                     input int erv, input int eres, input int eerr);
    vec_t v;
    v.dv = dv; v.dig = 4'(dig); v.bs = bs; v.clr = clr; v.sub = sub; v.rdy = rdy;
    v.e_value = ev; v.e_nd = end_; v.e_rv = erv; v.e_result = eres; v.e_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    digit_valid = 1'b0; digit = 4'd0; backspace = 1'b0; clear = 1'b0;
    submit = 1'b0; result_ready = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    digit_valid = v.dv; digit = v.dig; backspace = v.bs; clear = v.clr;
    submit = v.sub; result_ready = v.rdy;
    @(posedge clk);
    #1;
    check({tag, " value"}, int'(value), v.e_value);
    check({tag, " num_digits"}, int'(num_digits), v.e_nd);
    check({tag, " result_valid"}, int'(result_valid), v.e_rv);
    check({tag, " error"}, int'(error), v.e_err);
    if (v.e_rv != 0) check({tag, " result"}, int'(result), v.e_result);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " value"}, int'(value), 0);
    check({tag, " num_digits"}, int'(num_digits), 0);
    check({tag, " result_valid"}, int'(result_valid), 0);
    check({tag, " result"}, int'(result), 0);
    check({tag, " error"}, int'(error), 0);
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    rst_n = 1'b0;

    //      dv dig bs clr sub rdy  value nd rv res err
    add(1, 4, 0, 0, 0, 0,   4, 1, 0,  0, 0);
    add(1, 0, 0, 0, 0, 0,  40, 2, 0,  0, 0);
    add(1, 7, 0, 0, 0, 0, 407, 3, 0,  0, 0);
    add(1, 5, 0, 0, 0, 0, 407, 3, 0,  0, 1);  // full: rejected
    add(0, 0, 0, 0, 0, 0, 407, 3, 0,  0, 0);  // error lasts one cycle
    add(0, 0, 1, 0, 0, 0,  40, 2, 0,  0, 0);
    add(0, 0, 1, 0, 0, 0,   4, 1, 0,  0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0,  0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0,  0, 1);  // backspace when empty
    add(1, 9, 0, 0, 0, 0,   9, 1, 0,  0, 0);
    add(1, 9, 0, 0, 0, 0,  99, 2, 0,  0, 0);
    add(0, 0, 0, 0, 1, 0,  99, 2, 1, 99, 0);  // submit -> HOLD
    add(0, 0, 0, 0, 0, 0,  99, 2, 1, 99, 0);
    add(1, 3, 0, 0, 0, 0,  99, 2, 1, 99, 0);  // ignored in HOLD
    add(0, 0, 0, 1, 0, 0,  99, 2, 1, 99, 0);
    add(0, 0, 0, 0, 0, 0,  99, 2, 1, 99, 0);
    add(0, 0, 0, 0, 1, 0,  99, 2, 1, 99, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 99, 0);  // transfer
    add(1, 1, 0, 0, 0, 0,   1, 1, 0,  0, 0);
    add(1, 2, 0, 0, 0, 0,  12, 2, 0,  0, 0);
    add(1, 6, 0, 1, 0, 0,   0, 0, 0,  0, 0);  // clear beats digit
    add(1, 1, 0, 0, 0, 0,   1, 1, 0,  0, 0);
    add(1, 2, 0, 0, 0, 0,  12, 2, 0,  0, 0);
    add(0, 0, 1, 0, 1, 0,   1, 1, 0,  0, 0);  // backspace beats submit
    add(1, 12, 0, 0, 0, 0,  1, 1, 0,  0, 1);  // illegal digit
    add(0, 0, 0, 1, 0, 0,   0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 0, 0,  0, 1);  // submit when empty
    add(1, 0, 0, 0, 0, 0,   0, 1, 0,  0, 0);  // leading zero counts
    add(1, 7, 0, 0, 0, 0,   7, 2, 0,  0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 0, 0,  0, 0);
    add(1, 5, 0, 0, 0, 1,   5, 1, 0,  0, 0);  // ready high while entering
    add(0, 0, 0, 0, 1, 1,   5, 1, 1,  5, 0);  // ready with submit: no transfer yet
    add(0, 0, 0, 0, 0, 1,   0, 0, 0,  5, 0);  // single-cycle valid pulse

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of HOLD
    v = '{dv:1'b1, dig:4'd3, bs:1'b0, clr:1'b0, sub:1'b0, rdy:1'b0,
          e_value:3, e_nd:1, e_rv:0, e_result:0, e_err:0};
    apply(v, "hold_entry");
    v = '{dv:1'b0, dig:4'd0, bs:1'b0, clr:1'b0, sub:1'b1, rdy:1'b0,
          e_value:3, e_nd:1, e_rv:1, e_result:3, e_err:0};
    apply(v, "hold_submit");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    v = '{dv:1'b1, dig:4'd8, bs:1'b0, clr:1'b0, sub:1'b0, rdy:1'b0,
          e_value:8, e_nd:1, e_rv:0, e_result:0, e_err:0};
    apply(v, "post_reset");

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
